// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage RV64 pipeline.
// In: hazard/mem/redirect/ebreak status; out: per-register ena/valid,
// pc_ena, halt, err, perf counters (enabled with PIPE_CTRL_PERF_EN).
module pipe_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic        ex_load,
  input  logic        ex_rf_we,
  input  logic [4:0]  ex_rf_waddr,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        dmem_ready,
  input  logic        mem_ebreak,
  output logic        pc_ena,
  output logic        ifid_ena,
  output logic        ifid_valid,
  output logic        idex_ena,
  output logic        idex_valid,
  output logic        exmem_ena,
  output logic        exmem_valid,
  output logic        memwb_ena,
  output logic        memwb_valid,
  output logic        halt,
  output logic        err,
  output logic [63:0] stall_cycles,
  output logic [63:0] flush_count
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(MEM_TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic load_use;
  logic mem_stall;
  logic pc_c, ifid_e, ifid_v, idex_e, idex_v;
  logic exmem_e, exmem_v, memwb_e, memwb_v;
  logic halt_c;

  always_comb begin
    load_use = ex_load & ex_rf_we
             & (ex_rf_waddr != 5'd0)
             & ((id_rs1_used & (id_rs1 == ex_rf_waddr))
              | (id_rs2_used & (id_rs2 == ex_rf_waddr)));
    mem_stall = mem_req & ~dmem_ready;
  end

  always_comb begin
    pc_c    = 1'b1;
    ifid_e  = 1'b1;
    ifid_v  = 1'b1;
    idex_e  = 1'b1;
    idex_v  = 1'b1;
    exmem_e = 1'b1;
    exmem_v = 1'b1;
    memwb_e = 1'b1;
    memwb_v = 1'b1;
    halt_c  = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          pc_c    = 1'b0;
          ifid_e  = 1'b0;
          idex_e  = 1'b0;
          exmem_e = 1'b0;
          memwb_e = 1'b0;
          state_d = S_WAIT;
          cnt_d   = CNT_W'(1);
        end else if (mem_ebreak) begin
          pc_c    = 1'b0;
          ifid_v  = 1'b0;
          idex_v  = 1'b0;
          exmem_v = 1'b0;
          state_d = S_DRAIN;
        end else if (ex_redirect) begin
          ifid_v  = 1'b0;
          idex_v  = 1'b0;
        end else if (load_use) begin
          pc_c    = 1'b0;
          ifid_e  = 1'b0;
          idex_v  = 1'b0;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          pc_c    = 1'b0;
          ifid_e  = 1'b0;
          idex_e  = 1'b0;
          exmem_e = 1'b0;
          memwb_e = 1'b0;
          if (cnt_q == TMO) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        pc_c    = 1'b0;
        ifid_e  = 1'b0;
        idex_v  = 1'b0;
        exmem_v = 1'b0;
        state_d = S_HALT;
      end
      S_HALT: begin
        pc_c    = 1'b0;
        ifid_e  = 1'b0;
        idex_e  = 1'b0;
        exmem_e = 1'b0;
        memwb_e = 1'b0;
        halt_c  = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset flushes every register regardless of state.
  always_comb begin
    pc_ena      = rst_n & pc_c;
    ifid_ena    = rst_n & ifid_e;
    ifid_valid  = rst_n & ifid_v;
    idex_ena    = rst_n & idex_e;
    idex_valid  = rst_n & idex_v;
    exmem_ena   = rst_n & exmem_e;
    exmem_valid = rst_n & exmem_v;
    memwb_ena   = rst_n & memwb_e;
    memwb_valid = rst_n & memwb_v;
    halt        = rst_n & halt_c;
    err         = err_q;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [63:0] stall_q, stall_d;
  logic [63:0] flush_q, flush_d;
  logic        run_s, wait_s;

  always_comb begin
    run_s   = (state_q == S_RUN);
    wait_s  = (state_q == S_WAIT);
    stall_d = stall_q;
    flush_d = flush_q;
    if ((run_s | wait_s) & ~pc_c)
      stall_d = stall_q + 64'd1;
    if (run_s & ~mem_stall) begin
      if (mem_ebreak)
        flush_d = flush_q + 64'd3;
      else if (ex_redirect)
        flush_d = flush_q + 64'd2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;
`else
  assign stall_cycles = 64'd0;
  assign flush_count  = 64'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed + random checks of pipe_ctrl
// against a behavioural model of the stall/flush rules.
module tb_pipe_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rf_waddr;
  logic id_rs1_used, id_rs2_used;
  logic ex_load, ex_rf_we, ex_redirect;
  logic mem_req, dmem_ready, mem_ebreak;
  logic pc_ena, ifid_ena, ifid_valid;
  logic idex_ena, idex_valid;
  logic exmem_ena, exmem_valid;
  logic memwb_ena, memwb_valid;
  logic halt, err;
  logic [63:0] stall_cycles, flush_count;

  int tests = 0;
  int fails = 0;

  // model state
  bit      m_halted, m_drain, m_err;
  int      m_waits;
  longint  m_stall, m_flush;

  pipe_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .ex_load(ex_load), .ex_rf_we(ex_rf_we),
    .ex_rf_waddr(ex_rf_waddr),
    .ex_redirect(ex_redirect),
    .mem_req(mem_req), .dmem_ready(dmem_ready),
    .mem_ebreak(mem_ebreak),
    .pc_ena(pc_ena),
    .ifid_ena(ifid_ena), .ifid_valid(ifid_valid),
    .idex_ena(idex_ena), .idex_valid(idex_valid),
    .exmem_ena(exmem_ena), .exmem_valid(exmem_valid),
    .memwb_ena(memwb_ena), .memwb_valid(memwb_valid),
    .halt(halt), .err(err),
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic bit hazard();
    return ex_load && ex_rf_we && ex_rf_waddr != 0 &&
      ((id_rs1_used && id_rs1 == ex_rf_waddr) ||
       (id_rs2_used && id_rs2 == ex_rf_waddr));
  endfunction

  // order: pc, ifid e/v, idex e/v, exmem e/v, memwb e/v, halt, err
  function automatic logic [10:0] expect_out();
    logic [8:0] c;
    logic h;
    c = 9'h1FF;
    h = 1'b0;
    if (!rst_n) return 11'b0;
    if (m_halted) begin
      c = 9'b0_01_01_01_01;
      h = 1'b1;
    end else if (m_drain) begin
      c = 9'b0_01_10_10_11;
    end else if (m_waits > 0) begin
      if (!dmem_ready) c = 9'b0_01_01_01_01;
    end else if (mem_req && !dmem_ready) begin
      c = 9'b0_01_01_01_01;
    end else if (mem_ebreak) begin
      c = 9'b0_10_10_10_11;
    end else if (ex_redirect) begin
      c = 9'b1_10_10_11_11;
    end else if (hazard()) begin
      c = 9'b0_01_10_11_11;
    end
    return {c, h, m_err};
  endfunction

  task automatic model_step();
    logic [10:0] e;
    e = expect_out();
    if (!m_halted && !m_drain && !e[10]) m_stall++;
    if (m_halted) begin
    end else if (m_drain) begin
      m_drain = 0;
      m_halted = 1;
    end else if (m_waits > 0) begin
      if (dmem_ready) m_waits = 0;
      else if (m_waits == TMO) begin
        m_halted = 1;
        m_err = 1;
      end else m_waits++;
    end else if (mem_req && !dmem_ready) begin
      m_waits = 1;
    end else if (mem_ebreak) begin
      m_drain = 1;
      m_flush += 3;
    end else if (ex_redirect) begin
      m_flush += 2;
    end
  endtask

  task automatic check(string tag);
    logic [10:0] o, e;
    logic [63:0] es, ef;
    o = {pc_ena, ifid_ena, ifid_valid,
         idex_ena, idex_valid,
         exmem_ena, exmem_valid,
         memwb_ena, memwb_valid, halt, err};
    e = expect_out();
`ifdef PIPE_CTRL_PERF_EN
    es = m_stall;
    ef = m_flush;
`else
    es = 64'd0;
    ef = 64'd0;
`endif
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s ctl obs=%b exp=%b", tag, o, e);
    end
    tests++;
    assert ({stall_cycles, flush_count} === {es, ef})
    else begin
      fails++;
      $error("FAIL %s perf obs=%0d/%0d exp=%0d/%0d",
             tag, stall_cycles, flush_count, es, ef);
    end
  endtask

  // check at negedge+1, advance model for the coming posedge
  task automatic tick(string tag);
    #1;
    check(tag);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    ex_load = 0; ex_rf_we = 0; ex_rf_waddr = 0;
    ex_redirect = 0; mem_req = 0;
    dmem_ready = 0; mem_ebreak = 0;
  endtask

  task automatic model_reset();
    m_halted = 0; m_drain = 0; m_err = 0;
    m_waits = 0; m_stall = 0; m_flush = 0;
  endtask

  // asserted away from any clock edge
  task automatic reset_pulse(string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_lu(logic [4:0] rd);
    ex_load = 1; ex_rf_we = 1; ex_rf_waddr = rd;
    id_rs1 = 5; id_rs2 = 1;
    id_rs1_used = 1; id_rs2_used = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    #3 check("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    set_lu(5'd5);
    tick("lu_stall");
    idle();
    tick("lu_after");
    set_lu(5'd0);
    tick("lu_x0");
    idle();

    mem_req = 1; dmem_ready = 0;
    tick("mw_0");
    tick("mw_1");
    tick("mw_2");
    dmem_ready = 1;
    tick("mw_done");
    idle();
    tick("mw_run");

    set_lu(5'd5);
    ex_redirect = 1;
    tick("redir_lu");
    idle();
    tick("redir_after");

    mem_ebreak = 1;
    tick("ebreak");
    idle();
    tick("drain");
    for (int i = 0; i < 3; i++) tick("halted");
    reset_pulse("halt_rst");
    tick("after_halt");

    mem_req = 1; dmem_ready = 0;
    for (int i = 0; i < TMO + 1; i++) tick("to_wait");
    tick("to_halt");
    dmem_ready = 1;
    tick("to_hold");
    reset_pulse("to_rst");
    idle();
    tick("to_clear");

    mem_req = 1; dmem_ready = 0;
    tick("mid_w0");
    tick("mid_w1");
    reset_pulse("mid_rst");
    idle();
    mem_req = 1; dmem_ready = 1;
    tick("mid_after");

    for (int n = 0; n < 400; n++) begin
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_rs1_used = 1'($urandom);
      id_rs2_used = 1'($urandom);
      ex_load = 1'($urandom);
      ex_rf_we = ($urandom_range(0, 3) != 0);
      ex_rf_waddr = 5'($urandom_range(0, 3));
      ex_redirect = ($urandom_range(0, 5) == 0);
      mem_req = ($urandom_range(0, 2) == 0);
      dmem_ready = ($urandom_range(0, 4) < 3);
      mem_ebreak = ($urandom_range(0, 30) == 0);
      tick("rand");
      if ((m_halted && $urandom_range(0, 2) == 0) ||
          $urandom_range(0, 99) == 0)
        reset_pulse("rand_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV64 pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB registers plus PC).
- Drives each pipeline register's ena (hold when low) and valid (bubble when low; valid low overrides ena in the register).
- Handles load-use interlock, variable-latency data-memory wait, EX branch/jump redirect and ebreak drain/halt.
- Includes a memory-wait watchdog.

Parameters:
- MEM_TIMEOUT, 256, max consecutive MEM_WAIT cycles before the error halt.
- CNT_W, 9, width of the wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_load  in  1  EX instruction is a load
- ex_rf_we  in  1  EX instruction writes the register file
- ex_rf_waddr  in  5  EX destination register
- ex_redirect  in  1  EX-resolved taken branch or jump; PC loads the target
- mem_req  in  1  MEM stage has an active data-memory access
- dmem_ready  in  1  data memory completes the access this cycle
- mem_ebreak  in  1  ebreak instruction in the MEM stage
- pc_ena  out  1  PC update enable
- ifid_ena, ifid_valid  out  1 each  IF/ID controls
- idex_ena, idex_valid  out  1 each  ID/EX controls
- exmem_ena, exmem_valid  out  1 each  EX/MEM controls
- memwb_ena, memwb_valid  out  1 each  MEM/WB controls
- halt  out  1  core halted
- err  out  1  halted because of memory timeout
- stall_cycles  out  64  perf counter (see Optional Feature)
- flush_count  out  64  perf counter (see Optional Feature)

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALT. Reset enters RUN with wait_cnt=0 and err=0.
- While rst_n is low, all ena=0, all valid=0 (flush every register), halt=0.
- Outside reset, the defaults are: every ena=1, every valid=1.
- Outputs are combinational from state and inputs; state, wait_cnt and err are registered.

RUN, first matching row wins:
- mem_req & ~dmem_ready:
  - Freeze: all ena=0, all valid=1.
  - Next state MEM_WAIT, wait_cnt=1.
- mem_ebreak:
  - pc_ena=0.
  - ifid_valid=0, idex_valid=0, exmem_valid=0 (younger instructions squashed).
  - memwb_ena=1 so the ebreak retires.
  - Next state DRAIN.
- ex_redirect:
  - pc_ena=1.
  - ifid_valid=0, idex_valid=0 (2 squashed).
  - Older stages advance.
  - Redirect overrides a simultaneous load-use condition.
- load-use hazard:
  - Condition: ex_load & ex_rf_we & ex_rf_waddr!=0 & ((id_rs1_used & id_rs1==ex_rf_waddr) | (id_rs2_used & id_rs2==ex_rf_waddr)).
  - pc_ena=0, ifid_ena=0.
  - idex_valid=0 (one bubble).
  - exmem and memwb advance.
  - Exactly 1 stall cycle per hazard.

MEM_WAIT:
- dmem_ready=1: all ena=1 this cycle (the access completes), next state RUN, wait_cnt=0. No other event is evaluated in this cycle.
- Otherwise: freeze as above and increment wait_cnt.
- wait_cnt==MEM_TIMEOUT with dmem_ready=0: next state HALT, err=1.

DRAIN:
- pc_ena=0, ifid_ena=0, idex_valid=0, exmem_valid=0, memwb_ena=1.
- Next state HALT.

HALT:
- All ena=0, halt=1.
- Only rst_n leaves HALT.
- err holds its value until reset.

Other rules:
- Reset asserted mid-MEM_WAIT or mid-DRAIN returns to RUN immediately (asynchronous). wait_cnt and err clear.
- A load-use check against x0 never stalls.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- Defined:
  - stall_cycles increments on every non-reset cycle with pc_ena=0 in RUN or MEM_WAIT.
  - flush_count increments by 2 per redirect and by 3 per ebreak drain.
  - Both counters clear on reset, wrap at 2^64 and freeze in HALT.
- Undefined: both ports tied to 0, no counter flops.

Test Plan:
- Load-use: load x5 in EX, ID `add x6,x5,x1` with rs1_used=1 -> exactly 1 cycle with pc_ena=0, ifid_ena=0, idex_valid=0; following cycle all 1. Same stimulus with ex_rf_waddr=0 -> no stall.
- Memory wait: mem_req=1, dmem_ready low for 3 cycles then high -> 3 frozen cycles (all ena=0, valids=1), all ena=1 on the 4th cycle, state RUN.
- Redirect plus load-use in the same cycle -> pc_ena=1, ifid_valid=0, idex_valid=0, no stall next cycle; with PERF_EN, flush_count +2.
- Ebreak: mem_ebreak=1 -> DRAIN cycle (memwb_ena=1, exmem_valid=0) then halt=1 with all ena=0 indefinitely; rst_n pulse -> RUN, halt=0.
- Timeout with MEM_TIMEOUT=4 and dmem_ready held low -> HALT with err=1 after 4 wait cycles. Assert rst_n low mid-wait in a second run -> outputs reset with no clock edge required.
